// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Purpose  : Shared types for the iterative shifter. Holds the shift mode
//            encoding (also used by the ALU decoder), the FSM state type and a
//            helper that gives the number of BUSY steps.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

  // Mode encodings, exported so the ALU decoder can drive in_mode directly.
  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  localparam logic [1:0] MODE_SRL = 2'b11;

  typedef enum logic [1:0] {
    SH_SLL = MODE_SLL,
    SH_SRA = MODE_SRA,
    SH_ROR = MODE_ROR,
    SH_SRL = MODE_SRL
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } shift_state_e;

  // ceil(shamt_w / step_w): number of shift-amount digits processed.
  function automatic int num_steps(input int shamt_w, input int step_w);
    return (shamt_w + step_w - 1) / step_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Purpose  : Combinational single-step barrel shift of WIDTH bits by 'amount'
//            in the given mode. Right shifts fill with 'fill' (the caller
//            supplies the sign for SRA and 0 for SRL).
// Ports    : data_in  - operand
//            amount   - shift distance for this step (always < WIDTH in use)
//            mode     - SLL / SRA / ROR / SRL
//            fill     - fill bit for right shifts
//            data_out - shifted operand
//            carry    - last bit shifted out (meaningful when amount != 0)
// Revision : 1.0 - initial release
// ============================================================================
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  input  shift_mode_e      mode,
  input  logic             fill,
  output logic [WIDTH-1:0] data_out,
  output logic             carry
);

  logic [2*WIDTH-1:0] left_w;
  logic [2*WIDTH-1:0] fill_w;
  logic [2*WIDTH-1:0] rot_w;

  // Double-width vectors: the upper half of left_w catches bits leaving the
  // MSB; fill_w supplies fill bits from above; rot_w wraps the operand.
  assign left_w = {{WIDTH{1'b0}}, data_in} << amount;
  assign fill_w = {{WIDTH{fill}}, data_in} >> amount;
  assign rot_w  = {data_in, data_in} >> amount;

  always_comb begin
    data_out = data_in;
    carry    = 1'b0;
    unique case (mode)
      SH_SLL: begin
        data_out = left_w[WIDTH-1:0];
        carry    = left_w[WIDTH];          // original bit WIDTH-k
      end
      SH_ROR: begin
        data_out = rot_w[WIDTH-1:0];
        carry    = rot_w[WIDTH-1];         // original bit k-1
      end
      default: begin                       // SRA / SRL
        data_out = fill_w[WIDTH-1:0];
        carry    = rot_w[WIDTH-1];         // original bit k-1 lands here too
      end
    endcase
  end

  logic unused_hi;
  assign unused_hi = ^{left_w[2*WIDTH-1:WIDTH+1], fill_w[2*WIDTH-1:WIDTH],
                       rot_w[2*WIDTH-1:WIDTH]};

endmodule
`default_nettype wire

// File: rtl/iter_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : iter_shift_unit
// Purpose  : Multi-cycle shifter (SLL/SRA/ROR/SRL) consuming STEP_W bits of
//            the shift amount per BUSY cycle, with valid/ready on both sides.
//            Optional macro SHIFT_CARRY_EN adds the out_carry port.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready, in_data, in_shamt, in_mode - request side
//            out_valid/out_ready, out_data, [out_carry]   - result side
// Revision : 1.0 - initial release
// ============================================================================
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
`ifdef SHIFT_CARRY_EN
  ,
  output logic                     out_carry
`endif
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int NSTEP   = num_steps(SHAMT_W, STEP_W);
  localparam int AMT_W   = NSTEP * STEP_W;   // shamt padded to whole digits
  localparam int CNT_W   = $clog2(NSTEP + 1);

  shift_state_e      state_q, state_nxt;
  logic [WIDTH-1:0]  data_q;
  logic [AMT_W-1:0]  shamt_q;
  shift_mode_e       mode_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept;
  logic              last_step;
  logic [STEP_W-1:0] digit;
  logic [AMT_W-1:0]  step_amt;
  logic              fill;
  logic [WIDTH-1:0]  step_data;
  logic              step_carry;

  assign accept    = in_valid & in_ready;
  assign last_step = (cnt_q == CNT_W'(NSTEP - 1));
  // shamt_q is shifted down each step, so the current digit is always the LSBs.
  assign digit     = shamt_q[STEP_W-1:0];
  assign step_amt  = AMT_W'(digit) << (cnt_q * STEP_W);
  // The data MSB keeps the sign throughout an SRA, so it is the fill source.
  assign fill      = (mode_q == SH_SRA) & data_q[WIDTH-1];
  assign out_data  = data_q;

  shift_step #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_step (
    .data_in  (data_q),
    .amount   (step_amt),
    .mode     (mode_q),
    .fill     (fill),
    .data_out (step_data),
    .carry    (step_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;            // accept back-to-back on drain
        if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      shamt_q <= '0;
      mode_q  <= SH_SLL;
      cnt_q   <= '0;
    end else if (accept) begin
      data_q  <= in_data;
      shamt_q <= AMT_W'(in_shamt);
      mode_q  <= shift_mode_e'(in_mode);
      cnt_q   <= '0;
    end else if (state_q == BUSY) begin
      data_q  <= step_data;
      shamt_q <= shamt_q >> STEP_W;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

`ifdef SHIFT_CARRY_EN
  logic carry_q;

  // A zero digit shifts nothing out, so the previous carry is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (accept) begin
      carry_q <= 1'b0;
    end else if ((state_q == BUSY) && (digit != '0)) begin
      carry_q <= step_carry;
    end
  end

  assign out_carry = carry_q;
`else
  logic unused_carry;
  assign unused_carry = step_carry;
`endif

endmodule
`default_nettype wire
